// File: rtl/vector_mem_responder_if.sv
// Request/response channel between the processor memory stage (master) and the vector memory responder (slave).
interface vector_mem_responder_if #(
   parameter int registerSize = 8,
   parameter int vectorSize   = 4
);
   logic                                   req_valid;
   logic                                   req_ready;
   logic                                   req_write;
   logic                                   req_scalar;
   logic [15:0]                            req_addr;
   logic [vectorSize-1:0][registerSize-1:0] req_wdata;
   logic                                   rsp_valid;
   logic                                   rsp_ready;
   logic                                   rsp_write;
   logic [vectorSize-1:0][registerSize-1:0] rsp_rdata;

   modport master (
      output req_valid, req_write, req_scalar, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_write, rsp_rdata
   );

   modport slave (
      input  req_valid, req_write, req_scalar, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_write, rsp_rdata
   );
endinterface

// File: rtl/vector_mem_responder.sv
// Vector memory responder: serializes one load/store request onto a byte-lane RAM, one lane per cycle,
// then presents the load vector (or store ack) until the requester takes it.
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// READ  | reading one lane per cycle into the response register
// WRITE | writing one lane per cycle from the latched store data
// RESP  | response held on the bus until rsp_ready
module vector_mem_responder #(
   parameter int registerSize = 8,
   parameter int vectorSize   = 4,
   parameter int addrBits     = 8
) (
   input  logic clk,
   input  logic rst,
   vector_mem_responder_if.slave mem_if,
   output logic busy
);
   localparam int CNT_W = (vectorSize > 1) ? $clog2(vectorSize) : 1;
   localparam int DEPTH = 2 ** addrBits;

   typedef logic [vectorSize-1:0][registerSize-1:0] vec_t;
   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

   state_t                  state, state_nxt;
   logic [CNT_W-1:0]        lane_cnt;
   logic                    wr_q, scalar_q, rsp_write_q;
   logic [addrBits-1:0]     addr_q, lane_addr;
   vec_t                    wdata_q, rdata_q;
   logic [registerSize-1:0] ram [DEPTH];
   logic                    accept, last_lane;

   assign accept    = (state == IDLE) && mem_if.req_valid;
   assign last_lane = scalar_q || (lane_cnt == CNT_W'(vectorSize - 1));
   // Lane addresses wrap within the RAM depth; address bits above addrBits were dropped at latch time.
   assign lane_addr = addr_q + addrBits'(lane_cnt);

   always_comb begin
      state_nxt        = state;
      mem_if.req_ready = 1'b0;
      mem_if.rsp_valid = 1'b0;
      mem_if.rsp_write = rsp_write_q;
      mem_if.rsp_rdata = rdata_q;
      busy             = 1'b1;
      case (state)
         IDLE: begin
            mem_if.req_ready = 1'b1;
            busy             = 1'b0;
            if (mem_if.req_valid) state_nxt = mem_if.req_write ? WRITE : READ;
         end
         READ, WRITE: begin
            if (last_lane) state_nxt = RESP;
         end
         RESP: begin
            mem_if.rsp_valid = 1'b1;
            if (mem_if.rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         lane_cnt    <= '0;
         wr_q        <= 1'b0;
         scalar_q    <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         rsp_write_q <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            wr_q        <= mem_if.req_write;
            scalar_q    <= mem_if.req_scalar;
            addr_q      <= mem_if.req_addr[addrBits-1:0];
            wdata_q     <= mem_if.req_wdata;
            lane_cnt    <= '0;
            rdata_q     <= '0;
            rsp_write_q <= mem_if.req_write;
         end else if (state == READ || state == WRITE) begin
            lane_cnt <= last_lane ? '0 : lane_cnt + CNT_W'(1);
            if (state == READ) rdata_q[lane_cnt] <= ram[lane_addr];
         end
      end
   end

   // Storage is deliberately left out of reset: lanes written before a reset survive it.
   always_ff @(posedge clk) begin
      if (state == WRITE) ram[lane_addr] <= wdata_q[lane_cnt];
   end

   logic unused_ok;
   assign unused_ok = &{1'b0, wr_q, mem_if.req_addr[15:addrBits]};
endmodule
